fifo_18to36_ctrl: RTL and testbench

Single-clock FIFO controller that turns a RAMB16_S18_S36 primitive into a 16-to-32-bit width-converting FIFO. It accepts 16-bit halfwords plus 2 parity bits on a valid/ready write port and drives RAM port A. It reads 32-bit words plus 4 parity bits from RAM port B and presents them on a first-word-fall-through valid/ready read port. It sits directly upstream of the RAM, driving every RAM input, and directly downstream of it, consuming DOB/DOPB.

---
 rtl/fifo_18to36_pkg.sv | 32 +++
 rtl/fifo_18to36_skid.sv | 69 ++++++
 rtl/fifo_18to36_ctrl.sv | 119 +++++++++++
 tb/tb_fifo_18to36_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_18to36_pkg.sv
// Shared widths, depths and the output-stage word type for the 16-to-32 bit FIFO controller.
// Also holds the even-parity byte checker used when FIFO_PARITY_CHECK_EN is defined.
package fifo_18to36_pkg;

  localparam int HW_W     = 16;
  localparam int WD_W     = 32;
  localparam int HP_W     = 2;
  localparam int WP_W     = 4;
  localparam int DEPTH_HW = 1024;
  localparam int DEPTH_WD = 512;
  localparam int WPTR_W   = 11;
  localparam int RPTR_W   = 10;
  localparam int LVL_W    = 11;
  localparam int ADDRA_W  = 10;
  localparam int ADDRB_W  = 9;

  typedef struct packed {
    logic [WP_W-1:0] par;
    logic [WD_W-1:0] dat;
  } word_t;

  // High when any byte disagrees with its parity bit under even parity.
  function automatic logic par_bad(input word_t w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < WP_W; i++) begin
      bad = bad | ((^w.dat[8*i +: 8]) ^ w.par[i]);
    end
    return bad;
  endfunction

endpackage

// File: rtl/fifo_18to36_skid.sv
// Two-entry FWFT output buffer fed by the registered RAM port B; capture one edge after issue.
// Backpressure: rd_ready low holds the head; slot_ok tells the issuer whether a read may launch.
module fifo_18to36_skid
  import fifo_18to36_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       issue,
  input  logic       rd_ready,
  input  word_t      din,
  output logic       rd_valid,
  output word_t      head,
  output logic [1:0] occ,
  output logic       inf,
  output logic       slot_ok
);

  logic [1:0] occ_q;
  logic       inf_q;
  word_t      e0, e1;
  logic       pop, cap;

  assign pop      = rd_valid && rd_ready;
  // A read in flight during flush returns stale data, so its capture is dropped.
  assign cap      = inf_q && !flush;
  assign rd_valid = (occ_q != 2'd0);
  assign head     = e0;
  assign occ      = occ_q;
  assign inf      = inf_q;
  assign slot_ok  = ((occ_q + {1'b0, inf_q}) < 2'd2) || pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= 2'd0;
      inf_q <= 1'b0;
      e0    <= '0;
      e1    <= '0;
    end else if (flush) begin
      occ_q <= 2'd0;
      inf_q <= 1'b0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      inf_q <= issue;
      case ({cap, pop})
        2'b10: begin
          if (occ_q == 2'd0) e0 <= din;
          else               e1 <= din;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_18to36_ctrl.sv
// RAMB16_S18_S36 controller: 16b writes on port A, 32b FWFT reads from port B; word valid 2 edges after its 2nd halfword.
// Backpressure: wr_ready drops at LEVEL 1024 or flush; PAR_ERR checker built only with FIFO_PARITY_CHECK_EN.
module fifo_18to36_ctrl
  import fifo_18to36_pkg::*;
#(
  parameter logic [LVL_W-1:0] AFULL_LVL  = 11'd960,
  parameter logic [LVL_W-1:0] AEMPTY_LVL = 11'd4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [HW_W-1:0]    wr_data,
  input  logic [HP_W-1:0]    wr_par,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [WD_W-1:0]    rd_data,
  output logic [WP_W-1:0]    rd_par,
  output logic [LVL_W-1:0]   level,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               par_err,
  output logic [ADDRA_W-1:0] addra,
  output logic [HW_W-1:0]    dia,
  output logic [HP_W-1:0]    dipa,
  output logic               ena,
  output logic               wea,
  output logic               ssra,
  output logic [ADDRB_W-1:0] addrb,
  output logic [WD_W-1:0]    dib,
  output logic [WP_W-1:0]    dipb,
  output logic               enb,
  output logic               web,
  output logic               ssrb,
  input  logic [WD_W-1:0]    dob,
  input  logic [WP_W-1:0]    dopb
);

  logic [WPTR_W-1:0] wp;
  logic [RPTR_W-1:0] rp;
  logic              wr_acc, issue, slot_ok, inf;
  logic [1:0]        occ;
  word_t             head, din;

  // Pointers are registers, so LEVEL and the flags only see handshakes up to the last edge.
  assign level        = wp - {rp, 1'b0};
  assign full         = (level == LVL_W'(DEPTH_HW));
  assign empty        = (level < 11'd2) && (occ == 2'd0) && !inf;
  assign almost_full  = (level >= AFULL_LVL);
  assign almost_empty = (level <= AEMPTY_LVL);

  assign wr_ready = !full && !flush;
  assign wr_acc   = wr_valid && wr_ready;
  assign issue    = !flush && (level >= 11'd2) && slot_ok;

  assign ena   = wr_acc;
  assign wea   = wr_acc;
  assign addra = wp[ADDRA_W-1:0];
  assign dia   = wr_data;
  assign dipa  = wr_par;
  assign ssra  = 1'b0;

  assign enb   = issue;
  assign addrb = rp[ADDRB_W-1:0];
  assign web   = 1'b0;
  assign dib   = '0;
  assign dipb  = '0;
  assign ssrb  = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + WPTR_W'(wr_acc);
      rp <= rp + RPTR_W'(issue);
    end
  end

  assign din = '{par: dopb, dat: dob};

  fifo_18to36_skid u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .issue    (issue),
    .rd_ready (rd_ready),
    .din      (din),
    .rd_valid (rd_valid),
    .head     (head),
    .occ      (occ),
    .inf      (inf),
    .slot_ok  (slot_ok)
  );

  assign rd_data = head.dat;
  assign rd_par  = head.par;

`ifdef FIFO_PARITY_CHECK_EN
  logic par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               par_err_q <= 1'b0;
    else if (flush)                           par_err_q <= 1'b0;
    else if (inf && par_bad(din))             par_err_q <= 1'b1;
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_18to36_ctrl.sv
// Self-checking bench for fifo_18to36_ctrl with a behavioural RAMB16_S18_S36 and a halfword-queue reference model.
module tb_fifo_18to36_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, flush, wr_valid, rd_ready;
  logic [15:0] wr_data;
  logic [1:0]  wr_par;
  logic        wr_ready, rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  rd_par;
  logic [10:0] level;
  logic        full, empty, almost_full, almost_empty, par_err;
  logic [9:0]  addra;
  logic [15:0] dia;
  logic [1:0]  dipa;
  logic        ena, wea, ssra;
  logic [8:0]  addrb;
  logic [31:0] dib;
  logic [3:0]  dipb;
  logic        enb, web, ssrb;
  logic [31:0] dob = '0;
  logic [3:0]  dopb = '0;

  int checks = 0;
  int errors = 0;

  logic [17:0] acc_q[$];
  logic [35:0] got_q[$];

`ifdef FIFO_PARITY_CHECK_EN
  localparam logic PEXP = 1'b1;
`else
  localparam logic PEXP = 1'b0;
`endif

  always #5 clk = ~clk;

  fifo_18to36_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_par(wr_par),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_par(rd_par),
    .level(level), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .par_err(par_err),
    .addra(addra), .dia(dia), .dipa(dipa), .ena(ena), .wea(wea), .ssra(ssra),
    .addrb(addrb), .dib(dib), .dipb(dipb), .enb(enb), .web(web), .ssrb(ssrb),
    .dob(dob), .dopb(dopb)
  );

  // Behavioural dual-port RAM: halfword 2k -> low lane of word k, 2k+1 -> high lane.
  logic [15:0] mem_d [1024];
  logic [1:0]  mem_p [1024];
  always @(posedge clk) begin
    if (ena && wea) begin
      mem_d[addra] <= dia;
      mem_p[addra] <= dipa;
    end
    if (enb) begin
      dob  <= {mem_d[{addrb, 1'b1}], mem_d[{addrb, 1'b0}]};
      dopb <= {mem_p[{addrb, 1'b1}], mem_p[{addrb, 1'b0}]};
    end
  end

  function automatic logic [1:0] par_of(input logic [15:0] h);
    return {^h[15:8], ^h[7:0]};
  endfunction

  // Expected i-th output word: pair of accepted halfwords, older one in the low lane.
  function automatic logic [35:0] exp_word(input int i);
    logic [17:0] lo, hi;
    lo = acc_q[2*i];
    hi = acc_q[2*i+1];
    return {hi[17:16], lo[17:16], hi[15:0], lo[15:0]};
  endfunction

  // Settled LEVEL with reads stalled: up to two complete words migrate into the output buffer.
  function automatic int settled_level(input int n);
    int w;
    w = n / 2;
    if (w > 2) w = 2;
    return n - 2 * w;
  endfunction

  // One clock: record handshakes seen just before the edge, return on the following negedge.
  task automatic tick();
    logic wacc, racc;
    logic [35:0] w;
    #1;
    wacc = wr_valid && wr_ready;
    racc = rd_valid && rd_ready;
    w = {rd_par, rd_data};
    @(posedge clk);
    if (flush) begin
      acc_q.delete();
      got_q.delete();
    end else begin
      if (wacc) acc_q.push_back({wr_par, wr_data});
      if (racc) got_q.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic put(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_par   = par_of(d);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    wr_valid = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain(input int words, input int bound, output logic ok);
    int n;
    n = 0;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    while (got_q.size() < words && n < bound) begin
      tick();
      n++;
    end
    ok = (got_q.size() == words);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    wr_data = '0; wr_par = '0;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if ({rd_par, rd_data} !== 36'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", {rd_par, rd_data}); end
    checks++; if ({wr_ready, empty, full, almost_empty, almost_full, par_err} !== 6'b110100) begin
      errors++; $display("FAIL reset_flags got %b want 110100", {wr_ready, empty, full, almost_empty, almost_full, par_err}); end
    checks++; if (level !== 11'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if ({ena, enb, wea, web, ssra, ssrb} !== 6'b0) begin errors++; $display("FAIL reset_ram_ctl got %b want 000000", {ena, enb, wea, web, ssra, ssrb}); end
    checks++; if ({dib, dipb} !== 36'h0) begin errors++; $display("FAIL reset_dib got %h want 0", {dib, dipb}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    rd_ready = 1'b1;
    wr_valid = 1'b1; wr_data = 16'h1111; wr_par = par_of(16'h1111);
    #1;
    checks++; if ({ena, wea, addra, dia, dipa} !== {2'b11, 10'd0, 16'h1111, par_of(16'h1111)}) begin
      errors++; $display("FAIL porta_drive got %h want %h", {ena, wea, addra, dia, dipa}, {2'b11, 10'd0, 16'h1111, par_of(16'h1111)}); end
    tick();
    wr_data = 16'h2222; wr_par = par_of(16'h2222);
    #1;
    checks++; if (addra !== 10'd1) begin errors++; $display("FAIL porta_addr1 got %0d want 1", addra); end
    tick();
    wr_valid = 1'b0;
    checks++; if ({enb, addrb, rd_valid} !== {1'b1, 9'd0, 1'b0}) begin
      errors++; $display("FAIL issue_t got enb/addrb/vld %h want 1/0/0", {enb, addrb, rd_valid}); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL valid_t1 got %b want 0", rd_valid); end
    tick();
    checks++; if ({rd_valid, rd_par, rd_data} !== {1'b1, par_of(16'h2222), par_of(16'h1111), 32'h22221111}) begin
      errors++; $display("FAIL first_word got %b %h want 1 %h", rd_valid, {rd_par, rd_data}, {par_of(16'h2222), par_of(16'h1111), 32'h22221111}); end
    tick();
    checks++; if ({rd_valid, empty, level} !== {1'b0, 1'b1, 11'd0}) begin
      errors++; $display("FAIL after_pop got %h want %h", {rd_valid, empty, level}, {1'b0, 1'b1, 11'd0}); end
  endtask

  task automatic test_odd_halfword();
    logic quiet;
    do_flush();
    rd_ready = 1'b0;
    put(16'hABCD);
    quiet = 1'b1;
    repeat (4) begin
      if (rd_valid !== 1'b0 || empty !== 1'b1) quiet = 1'b0;
      tick();
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL lone_half got vld %b empty %b want 0 1", rd_valid, empty); end
    checks++; if (level !== 11'(settled_level(1))) begin errors++; $display("FAIL lone_level got %0d want %0d", level, settled_level(1)); end
    put(16'h0001);
    repeat (3) tick();
    checks++; if ({rd_valid, rd_data} !== {1'b1, 32'h0001ABCD}) begin errors++; $display("FAIL pair_word got %b %h want 1 0001abcd", rd_valid, rd_data); end
    checks++; if ({empty, level} !== {1'b0, 11'(settled_level(2))}) begin errors++; $display("FAIL pair_state got %h want %h", {empty, level}, {1'b0, 11'(settled_level(2))}); end
  endtask

  task automatic test_full();
    logic ok;
    int flag_bad;
    int n;
    do_flush();
    flag_bad = 0;
    rd_ready = 1'b0;
    n = 0;
    while (n < 1200) begin
      wr_valid = 1'b1;
      wr_data = 16'($urandom);
      wr_par = par_of(wr_data);
      tick();
      n++;
      if (almost_full !== (level >= 11'd960) || almost_empty !== (level <= 11'd4) || full !== (level == 11'd1024)) flag_bad++;
      if (wr_ready !== 1'b1) break;
    end
    // Two words sit in the output buffer, so four extra halfwords fit before FULL.
    checks++; if (acc_q.size() != 1028) begin errors++; $display("FAIL fill_count got %0d want 1028", acc_q.size()); end
    repeat (3) tick();
    checks++; if (acc_q.size() != 1028) begin errors++; $display("FAIL stall_write got %0d want 1028", acc_q.size()); end
    checks++; if ({full, wr_ready, almost_full, almost_empty, empty, rd_valid} !== 6'b101001) begin
      errors++; $display("FAIL full_flags got %b want 101001", {full, wr_ready, almost_full, almost_empty, empty, rd_valid}); end
    checks++; if (level !== 11'(settled_level(1028))) begin errors++; $display("FAIL full_level got %0d want %0d", level, settled_level(1028)); end
    wr_valid = 1'b0;
    n = 0;
    while (got_q.size() < 514 && n < 4000) begin
      rd_ready = ($urandom % 2) == 0;
      tick();
      n++;
      if (almost_full !== (level >= 11'd960) || almost_empty !== (level <= 11'd4) || full !== (level == 11'd1024)) flag_bad++;
    end
    drain(514, 100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_drain got %0d words want 514", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_word(i)) begin errors++; $display("FAIL full_data[%0d] got %h want %h", i, got_q[i], exp_word(i)); end
    end
    checks++; if (flag_bad != 0) begin errors++; $display("FAIL level_flags got %0d bad cycles want 0", flag_bad); end
  endtask

  task automatic test_stream();
    logic ok;
    int n;
    do_flush();
    n = 0;
    while (acc_q.size() < 3000 && n < 20000) begin
      wr_valid = ($urandom % 4) != 0;
      wr_data = 16'($urandom);
      wr_par = par_of(wr_data);
      rd_ready = ($urandom % 3) != 0;
      tick();
      n++;
    end
    checks++; if (acc_q.size() != 3000) begin errors++; $display("FAIL stream_in got %0d want 3000", acc_q.size()); end
    drain(1500, 3000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stream_out got %0d words want 1500", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_word(i)) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", i, got_q[i], exp_word(i)); end
    end
    repeat (3) tick();
    checks++; if ({rd_valid, empty, level} !== {1'b0, 1'b1, 11'd0}) begin
      errors++; $display("FAIL stream_end got %h want %h", {rd_valid, empty, level}, {1'b0, 1'b1, 11'd0}); end
  endtask

  task automatic test_back_to_back();
    logic ok;
    int low;
    do_flush();
    rd_ready = 1'b0;
    repeat (400) begin
      wr_valid = 1'b1;
      wr_data = 16'($urandom);
      wr_par = par_of(wr_data);
      tick();
    end
    low = 0;
    rd_ready = 1'b1;
    repeat (150) begin
      wr_data = 16'($urandom);
      wr_par = par_of(wr_data);
      if (rd_valid !== 1'b1) low++;
      tick();
    end
    checks++; if (low != 0) begin errors++; $display("FAIL b2b_valid got %0d idle cycles want 0", low); end
    checks++; if (got_q.size() != 150) begin errors++; $display("FAIL b2b_rate got %0d words want 150", got_q.size()); end
    drain(acc_q.size() / 2, 1000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_drain got %0d words want %0d", got_q.size(), acc_q.size() / 2); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_word(i)) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, got_q[i], exp_word(i)); end
    end
  endtask

  task automatic test_flush();
    logic stayed;
    do_flush();
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) put(16'(16'h0100 + i));
    repeat (3) tick();
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL pre_flush_valid got %b want 1", rd_valid); end
    rd_ready = 1'b1;
    tick();
    // A refill read is now in flight behind the remaining buffered word.
    rd_ready = 1'b0;
    flush = 1'b1;
    wr_valid = 1'b1;
    wr_data = 16'hDEAD;
    wr_par = par_of(16'hDEAD);
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL flush_wr_ready got %b want 0", wr_ready); end
    tick();
    flush = 1'b0;
    wr_valid = 1'b0;
    checks++; if ({rd_valid, empty, level} !== {1'b0, 1'b1, 11'd0}) begin
      errors++; $display("FAIL flush_state got %h want %h", {rd_valid, empty, level}, {1'b0, 1'b1, 11'd0}); end
    stayed = 1'b1;
    repeat (3) begin
      tick();
      if (rd_valid !== 1'b0 || level !== 11'd0) stayed = 1'b0;
    end
    checks++; if (stayed !== 1'b1) begin errors++; $display("FAIL flush_stale got vld %b level %0d want 0 0", rd_valid, level); end
    put(16'h5555);
    put(16'h6666);
    repeat (3) tick();
    checks++; if ({rd_valid, rd_data} !== {1'b1, 32'h66665555}) begin errors++; $display("FAIL post_flush_word got %b %h want 1 66665555", rd_valid, rd_data); end
  endtask

  task automatic test_parity();
    do_flush();
    rd_ready = 1'b0;
    wr_valid = 1'b1; wr_data = 16'h00FF; wr_par = 2'b01; tick();
    wr_data = 16'h0000; wr_par = 2'b00; tick();
    wr_valid = 1'b0;
    tick();
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_early got %b want 0", par_err); end
    tick();
    checks++; if (par_err !== PEXP) begin errors++; $display("FAIL par_set got %b want %b", par_err, PEXP); end
    rd_ready = 1'b1;
    tick();
    put(16'h1234);
    put(16'h5678);
    repeat (4) tick();
    checks++; if (par_err !== PEXP) begin errors++; $display("FAIL par_sticky got %b want %b", par_err, PEXP); end
    do_flush();
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_flush got %b want 0", par_err); end
  endtask

  task automatic test_async_reset();
    do_flush();
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(16'(16'h0A00 + i));
    repeat (3) tick();
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b want 1", rd_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({rd_valid, empty, wr_ready, level, rd_data} !== {3'b011, 11'd0, 32'h0}) begin
      errors++; $display("FAIL async_reset got %h want %h", {rd_valid, empty, wr_ready, level, rd_data}, {3'b011, 11'd0, 32'h0}); end
    @(negedge clk);
    rst_n = 1'b1;
    acc_q.delete();
    got_q.delete();
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_odd_halfword();
    test_full();
    test_stream();
    test_back_to_back();
    test_flush();
    test_parity();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
